// File: rtl/ch2_pkg.sv
// Shared constants for the chapter-2 frequency meter: FSM encodings and
// default parameter values.
package ch2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_GATE   = 2'd1;
  localparam state_t S_FINISH = 2'd2;

  localparam int GATE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/ch2_edge_det.sv
// Two-flop synchronizer followed by a registered falling-edge strobe.
// A falling edge on D shows up as a one-cycle FALL three clock edges later.
module ch2_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic FALL
);

  logic sync1, sync2, hist;

  // Synchronize D, keep one cycle of history, and register the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      sync1 <= D;
      sync2 <= sync1;
      hist  <= sync2;
      FALL  <= hist & ~sync2;
    end
  end

endmodule

// File: rtl/ch2_freq_meter.sv
// Gated frequency meter: counts falling edges of SIG_IN over a window of
// GATE_CYCLES clocks and publishes the (saturating) count with a DONE pulse.
module ch2_freq_meter
  import ch2_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIG_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             fall;

  ch2_edge_det u_edge (
    .CLK  (CLK),
    .RST  (RST),
    .D    (SIG_IN),
    .FALL (fall)
  );

  // Saturating increment; an edge arriving at full scale marks overflow.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (fall) begin
      if (cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                cnt_nxt = cnt + 1'b1;
    end
  end

  // FSM, gate timer, edge counter and result registers. The result is
  // loaded on the GATE->FINISH edge so it includes a strobe in the last
  // gate cycle and is visible together with DONE during FINISH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      timer <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      COUNT <= '0;
      OVF   <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_GATE;
            timer <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        S_GATE: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          if (timer == T_LAST) begin
            state <= S_FINISH;
            COUNT <= cnt_nxt;
            OVF   <= ovf_nxt;
            DONE  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_GATE);

endmodule

// File: tb/tb_ch2_freq_meter.sv
// Directed bench for ch2_freq_meter. Two instances share stimulus: a 16-bit
// counter and a 4-bit counter (to exercise saturation), both GATE_CYCLES=100.
module tb_ch2_freq_meter;

  logic        clk = 1'b0;
  logic        rst, start, sig_in;
  logic        busy, done, ovf;
  logic [15:0] count;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  always #5 clk = ~clk;

  ch2_freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .SIG_IN(sig_in),
    .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
  );

  ch2_freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start), .SIG_IN(sig_in),
    .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // period 0 means a static level given by ph; otherwise a square wave of
  // the given period whose falling edges land on cycles ph (mod period).
  typedef struct {
    int    period;
    int    ph;
    int    exp16;
    int    exp4;
    int    ovf4;
    bit    extra;
    bit    b2b;
    string name;
  } vec_t;

  function automatic vec_t mk(int p, int ph, int e16, int e4, int o4, bit ex, bit bb, string nm);
    vec_t v;
    v.period = p; v.ph = ph; v.exp16 = e16; v.exp4 = e4; v.ovf4 = o4;
    v.extra = ex; v.b2b = bb; v.name = nm;
    return v;
  endfunction

  function automatic logic sig_at(int p, int ph, int c);
    if (p == 0) return ph[0];
    return (((c - ph + 1000 * p) % p) < p / 2) ? 1'b0 : 1'b1;
  endfunction

  // One measurement (or two back-to-back). Cycle c is observed mid-cycle at
  // the falling clock edge, then that cycle's inputs are driven.
  task automatic run(input vec_t v);
    int   errs = 0;
    int   ndone = 0;
    int   last;
    logic eb, ed;
    start  = 1'b0;
    sig_in = sig_at(v.period, v.ph, 0);
    repeat (6) @(negedge clk);
    last = v.b2b ? 206 : 106;
    for (int c = 0; c <= last; c++) begin
      eb = (c >= 1 && c <= 100) || (v.b2b && c >= 103 && c <= 202);
      ed = (c == 101) || (v.b2b && c == 203);
      if (busy !== eb || busy4 !== eb) errs++;
      if (done !== ed || done4 !== ed) errs++;
      if (done === 1'b1) ndone++;
      if (ed) begin
        chk({v.name, ":count16"}, 32'(count),  32'(v.exp16));
        chk({v.name, ":ovf16"},   32'(ovf),    32'd0);
        chk({v.name, ":count4"},  32'(count4), 32'(v.exp4));
        chk({v.name, ":ovf4"},    32'(ovf4),   32'(v.ovf4));
      end
      start  = (c == 0) || (v.extra && (c == 50 || c == 101)) || (v.b2b && c == 102);
      sig_in = sig_at(v.period, v.ph, c);
      @(negedge clk);
    end
    chk({v.name, ":busy_done_seq_errs"}, 32'(errs), 32'd0);
    chk({v.name, ":done_pulses"}, 32'(ndone), v.b2b ? 32'd2 : 32'd1);
  endtask

  vec_t tbl[11];
  int   errs;

  initial begin
    tbl[0]  = mk(10,  3, 10, 10, 0, 1'b0, 1'b0, "nominal_p10");
    tbl[1]  = mk(0,   0,  0,  0, 0, 1'b0, 1'b0, "static_low");
    tbl[2]  = mk(0,   1,  0,  0, 0, 1'b0, 1'b0, "static_high");
    tbl[3]  = mk(4,   3, 24, 15, 1, 1'b0, 1'b0, "saturate_p4");
    tbl[4]  = mk(0,   0,  0,  0, 0, 1'b0, 1'b0, "static_after_sat");
    tbl[5]  = mk(6,   3, 16, 15, 1, 1'b0, 1'b0, "p6_sat_by_one");
    tbl[6]  = mk(8,   3, 12, 12, 0, 1'b0, 1'b0, "p8");
    tbl[7]  = mk(200, 97, 1,  1, 0, 1'b0, 1'b0, "strobe_last_gate_cycle");
    tbl[8]  = mk(200, 98, 0,  0, 0, 1'b0, 1'b0, "strobe_in_finish");
    tbl[9]  = mk(10,  3, 10, 10, 0, 1'b1, 1'b0, "ignored_start");
    tbl[10] = mk(10,  3, 10, 10, 0, 1'b0, 1'b1, "back_to_back");

    // Reset state.
    rst = 1'b1; start = 1'b0; sig_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset:busy",  32'(busy),  32'd0);
    chk("reset:done",  32'(done),  32'd0);
    chk("reset:count", 32'(count), 32'd0);
    chk("reset:ovf",   32'(ovf4),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run(tbl[i]);

    // Reset in the middle of a gate window after a result of 10 is held.
    errs = 0;
    for (int c = 0; c <= 110; c++) begin
      if (c == 30) chk("midrst:busy_before", 32'(busy), 32'd1);
      if (c == 40) chk("midrst:count_held",  32'(count), 32'd10);
      if (c == 41) begin
        chk("midrst:busy",   32'(busy),   32'd0);
        chk("midrst:count",  32'(count),  32'd0);
        chk("midrst:ovf",    32'(ovf),    32'd0);
        chk("midrst:count4", 32'(count4), 32'd0);
      end
      if (c >= 41 && (done !== 1'b0 || done4 !== 1'b0 || busy !== 1'b0)) errs++;
      start  = (c == 0);
      rst    = (c == 40);
      sig_in = sig_at(10, 3, c);
      @(negedge clk);
    end
    chk("midrst:no_done_after", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
